instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
// - Fetch sequencer that drives the program_counter control inputs (IN, load, CE) and consumes its OUT value.
// - Reads synchronous instruction memory (1-cycle read latency) at the PC address.
// - Delivers each instruction to the decoder over a valid/ready handshake.
// - Accepts jump redirects from the decoder and reloads the PC.
// PARAMETERS
// - ADDR_W      16  PC / memory address width
// - DATA_W      16  instruction width
// - MEM_DEPTH   256 instruction memory words; used only by the bound check
// - RESET_ADDR  0   PC value loaded after reset
// PORTS
// - clk          in   1       single clock; all state changes on posedge
// - rst          in   1       synchronous, active-high reset
// - pc_value     in   ADDR_W  program_counter OUT
// - pc_in        out  ADDR_W  program_counter IN
// - pc_load      out  1       program_counter load
// - pc_ce        out  1       program_counter CE (increment)
// - mem_addr     out  ADDR_W  instruction memory address (= pc_value)
// - mem_en       out  1       instruction memory read enable
// - mem_rdata    in   DATA_W  memory data, valid one cycle after mem_en
// - instr        out  DATA_W  registered instruction
// - instr_valid  out  1       instr holds an undelivered instruction
// - instr_ready  in   1       decoder accepts instr this cycle
// - jump_req     in   1       redirect; sampled only on a valid&ready handshake
// - jump_addr    in   ADDR_W  redirect target
// - halt         in   1       suspend fetching; checked in FETCH only
// - fault        out  1       out-of-range fetch (IFETCH_BOUND_CHECK_EN only; otherwise tied 0)
// BEHAVIOUR
// - The PC is external: on posedge it loads IN when load=1; otherwise it increments when CE=1. load has priority.
// - States: LOAD, FETCH, WAIT, VALID, FAULT. Outputs decode from state; instr is a register.
// - Reset: state=LOAD, instr=0, instr_valid=0, fault=0.
//   - While rst is high: pc_load=1, pc_in=RESET_ADDR, pc_ce=0, mem_en=0.
// - LOAD: pc_load=1, pc_in=RESET_ADDR or the latched jump target. Next state: FETCH.
// - FETCH, halt=1: all outputs idle. Stay in FETCH.
// - FETCH, halt=0: mem_en=1, mem_addr=pc_value, pc_ce=1. Next state: WAIT.
// - WAIT: mem_en=0, pc_ce=0. instr<=mem_rdata on the closing edge. Next state: VALID.
// - VALID: instr_valid=1; instr and instr_valid stay stable until instr_ready=1.
//   - instr_ready=1, jump_req=0: next state FETCH.
//   - instr_ready=1, jump_req=1: latch jump_addr, next state LOAD.
//     The PC already points past the fetched word, so the redirect discards that sequential address.
// - Latency: first instr_valid in the 4th cycle after rst is sampled low (LOAD, FETCH, WAIT, VALID).
// - Throughput with instr_ready held at 1: one instruction per 3 cycles; a jump adds 1 cycle.
// - Boundary cases:
//   - jump_req outside a handshake is ignored.
//   - halt during VALID does not withdraw instr; it takes effect at the next FETCH.
//   - jump_req and halt together: the jump loads first, then fetching halts in FETCH.
//   - PC wrap at 2^ADDR_W-1 -> 0 is the PC's own behaviour; the block does not check it.
//   - rst in any state: the next cycle is LOAD, instr_valid=0, and any in-flight read is discarded.
//   - Widths: pc_in, mem_addr and jump_addr are ADDR_W with no truncation. instr is DATA_W.
// CONFIGURATION
// - Macro IFETCH_BOUND_CHECK_EN.
// - Defined:
//   - In FETCH with halt=0 and pc_value >= MEM_DEPTH: mem_en=0, pc_ce=0, next state FAULT.
//   - FAULT: fault=1 and sticky; no memory reads, no PC control. Only rst exits FAULT.
// - Undefined:
//   - No FAULT state; fault is constant 0.
//   - Any pc_value is fetched; the memory uses its low address bits.
// TESTING
// - Reset, mem[0]=16'h1111, mem[1]=16'h2222, ready=1
//   -> pc_load=1, pc_in=0 during rst; first instr=1111 with valid=1 in the 4th cycle; then 2222 three cycles later.
// - ready=0 for 5 cycles while valid
//   -> instr and valid hold steady; mem_en=0 and pc_ce=0 throughout; delivery resumes the cycle after ready=1.
// - jump_req=1, jump_addr=10 on the handshake of the instr at address 3
//   -> LOAD with pc_in=10; next fetch has mem_addr=10; the word at address 4 is never delivered.
// - halt=1 held in FETCH for 6 cycles, then 0
//   -> no mem_en or pc_ce while halted; fetch resumes at an unchanged pc_value.
// - rst pulsed for 1 cycle while in WAIT
//   -> instr_valid=0; the stale mem_rdata is never presented; the PC is reloaded to RESET_ADDR.
// - IFETCH_BOUND_CHECK_EN, MEM_DEPTH=8, jump to 8
//   -> fault=1 two cycles after the jump handshake, mem_en stays 0; stays so until rst.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch sequencer for an external PC and a 1-cycle synchronous instruction memory
//
// Sequences LOAD -> FETCH -> WAIT -> VALID, driving the program counter's
// IN/load/CE controls and handing each fetched word to the decoder over a
// valid/ready handshake. A jump taken on the handshake reloads the PC.
//
// Optional feature macro: IFETCH_BOUND_CHECK_EN
//   defined   : a fetch with pc_value >= MEM_DEPTH enters a sticky FAULT state
//   undefined : no FAULT state, fault tied to 0, every pc_value is fetched
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   pc_value     program counter OUT
//   pc_in        program counter IN (reset address or latched jump target)
//   pc_load      program counter load (priority over pc_ce)
//   pc_ce        program counter increment enable
//   mem_addr     instruction memory address (= pc_value)
//   mem_en       instruction memory read enable
//   mem_rdata    memory read data, valid one cycle after mem_en
//   instr        registered instruction
//   instr_valid  instr holds an undelivered instruction
//   instr_ready  decoder accepts instr this cycle
//   jump_req     redirect request, honoured only on a handshake
//   jump_addr    redirect target
//   halt         suspends fetching while in FETCH
//   fault        out-of-range fetch detected (sticky until rst)

module instruction_fetch #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter int                MEM_DEPTH  = 256,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_value,
    output logic [ADDR_W-1:0] pc_in,
    output logic              pc_load,
    output logic              pc_ce,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FETCH,
        S_WAIT,
        S_VALID
`ifdef IFETCH_BOUND_CHECK_EN
        , S_FAULT
`endif
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   instr_q;
    logic                instr_valid_q;
    logic [ADDR_W-1:0]   target_q;      // address presented on pc_in in LOAD
    logic                out_of_range;

`ifdef IFETCH_BOUND_CHECK_EN
    // One extra bit so MEM_DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);
    logic fault_q;

    assign out_of_range = ({1'b0, pc_value} >= MEM_LIMIT);
    assign fault        = fault_q;
`else
    assign out_of_range = 1'b0;
    assign fault        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            target_q      <= RESET_ADDR;
`ifdef IFETCH_BOUND_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (!halt) begin
`ifdef IFETCH_BOUND_CHECK_EN
                        if (out_of_range) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
`else
                        state_q <= S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    instr_q       <= mem_rdata;
                    instr_valid_q <= 1'b1;
                    state_q       <= S_VALID;
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (jump_req) begin
                            // PC already advanced past this word; the reload discards that address.
                            target_q <= jump_addr;
                            state_q  <= S_LOAD;
                        end else begin
                            state_q  <= S_FETCH;
                        end
                    end
                end
`ifdef IFETCH_BOUND_CHECK_EN
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
`endif
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    // PC and memory controls; rst overrides the state so the PC is held at RESET_ADDR.
    always_comb begin
        pc_load = 1'b0;
        pc_in   = target_q;
        pc_ce   = 1'b0;
        mem_en  = 1'b0;
        if (rst) begin
            pc_load = 1'b1;
            pc_in   = RESET_ADDR;
        end else begin
            case (state_q)
                S_LOAD: begin
                    pc_load = 1'b1;
                end
                S_FETCH: begin
                    if (!halt && !out_of_range) begin
                        mem_en = 1'b1;
                        pc_ce  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr    = pc_value;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch with PC and memory models

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_value = 16'h0000;
    logic [15:0] pc_in;
    logic        pc_load;
    logic        pc_ce;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_rdata = 16'hDEAD;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_req;
    logic [15:0] jump_addr;
    logic        halt;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_value    (pc_value),
        .pc_in       (pc_in),
        .pc_load     (pc_load),
        .pc_ce       (pc_ce),
        .mem_addr    (mem_addr),
        .mem_en      (mem_en),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_req    (jump_req),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .fault       (fault)
    );

    // Environment: external program counter and synchronous instruction memory.
    always @(posedge clk) begin
        if (pc_load)
            pc_value <= pc_in;
        else if (pc_ce)
            pc_value <= pc_value + 16'd1;
        if (mem_en)
            mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst         = 1'b1;
        instr_ready = 1'b0;
        jump_req    = 1'b0;
        halt        = 1'b0;
        jump_addr   = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Counts cycles (by negedge) until instr_valid is seen; -1 on timeout.
    task automatic wait_valid(input int max_cycles, output int cycles);
        cycles = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                cycles = c;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int c;
        rst         = 1'b1;
        instr_ready = 1'b0;
        jump_req    = 1'b0;
        halt        = 1'b0;
        jump_addr   = 16'h0000;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1 || pc_in !== 16'h0000 || pc_ce !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pc_ctrl: load=%b in=%h ce=%b en=%b required load=1 in=0000 ce=0 en=0",
                     pc_load, pc_in, pc_ce, mem_en);
        end
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b instr=%h fault=%b required 0/0000/0",
                     instr_valid, instr, fault);
        end
        tick();
        rst         = 1'b0;
        instr_ready = 1'b1;
        wait_valid(10, c);
        n_checks++;
        if (c !== 4) begin
            n_fail++;
            $display("FAIL first_latency: got %0d cycles required 4", c);
        end
        n_checks++;
        if (instr !== 16'h1111) begin
            n_fail++;
            $display("FAIL first_instr: got %h required 1111", instr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 3 || instr !== 16'h2222) begin
            n_fail++;
            $display("FAIL second_instr: gap=%0d instr=%h required gap=3 instr=2222", c, instr);
        end
    endtask

    task automatic test_backpressure();
        int c;
        logic [15:0] held;
        do_reset();
        wait_valid(10, c);
        held      = instr;
        // jump_req without a handshake must be ignored
        jump_req  = 1'b1;
        jump_addr = 16'h0077;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== mem[0] || instr !== held || mem_en !== 1'b0 || pc_ce !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h en=%b ce=%b required 1/%h/0/0",
                         i, instr_valid, instr, mem_en, pc_ce, mem[0]);
            end
            @(negedge clk);
        end
        jump_req    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 16'h0001) begin
            n_fail++;
            $display("FAIL stall_resume: valid=%b en=%b addr=%h required 0/1/0001",
                     instr_valid, mem_en, mem_addr);
        end
    endtask

    task automatic test_jump();
        int c;
        do_reset();
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(10, c);
            n_checks++;
            if (instr !== mem[k]) begin
                n_fail++;
                $display("FAIL jump_seq[%0d]: got %h required %h", k, instr, mem[k]);
            end
        end
        jump_req  = 1'b1;
        jump_addr = 16'd10;
        tick();
        jump_req  = 1'b0;
        jump_addr = 16'h5555;
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1 || pc_in !== 16'd10) begin
            n_fail++;
            $display("FAIL jump_load: load=%b in=%h required 1/000a", pc_load, pc_in);
        end
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'd10) begin
            n_fail++;
            $display("FAIL jump_fetch: en=%b addr=%h required 1/000a", mem_en, mem_addr);
        end
        wait_valid(10, c);
        n_checks++;
        if (instr !== mem[10]) begin
            n_fail++;
            $display("FAIL jump_target_instr: got %h required %h", instr, mem[10]);
        end
    endtask

    task automatic test_halt();
        int c;
        do_reset();
        instr_ready = 1'b1;
        wait_valid(10, c);
        halt = 1'b1;
        #1;
        n_checks++;
        if (instr_valid !== 1'b1 || instr !== mem[0]) begin
            n_fail++;
            $display("FAIL halt_in_valid: valid=%b instr=%h required 1/%h", instr_valid, instr, mem[0]);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== 1'b0 || pc_ce !== 1'b0 || instr_valid !== 1'b0 || pc_value !== 16'd1) begin
                n_fail++;
                $display("FAIL halted[%0d]: en=%b ce=%b valid=%b pc=%h required 0/0/0/0001",
                         i, mem_en, pc_ce, instr_valid, pc_value);
            end
        end
        tick();
        halt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || pc_ce !== 1'b1 || mem_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL halt_resume: en=%b ce=%b addr=%h required 1/1/0001", mem_en, pc_ce, mem_addr);
        end
        wait_valid(10, c);
        // jump and halt together: the load happens, then fetching halts
        jump_req  = 1'b1;
        jump_addr = 16'd20;
        halt      = 1'b1;
        tick();
        jump_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1 || pc_in !== 16'd20) begin
            n_fail++;
            $display("FAIL jump_halt_load: load=%b in=%h required 1/0014", pc_load, pc_in);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== 1'b0 || pc_value !== 16'd20) begin
                n_fail++;
                $display("FAIL jump_halt_hold[%0d]: en=%b pc=%h required 0/0014", i, mem_en, pc_value);
            end
        end
        tick();
        halt = 1'b0;
        wait_valid(10, c);
        n_checks++;
        if (instr !== mem[20]) begin
            n_fail++;
            $display("FAIL jump_halt_instr: got %h required %h", instr, mem[20]);
        end
    endtask

    task automatic test_reset_in_wait();
        int c;
        do_reset();
        instr_ready = 1'b1;
        wait_valid(10, c);
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'd1) begin
            n_fail++;
            $display("FAIL pre_wait_fetch: en=%b addr=%h required 1/0001", mem_en, mem_addr);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pc_load !== 1'b1 || pc_in !== 16'h0000 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_wait_ctrl: load=%b in=%h en=%b required 1/0000/0", pc_load, pc_in, mem_en);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_in_wait_flush: valid=%b instr=%h required 0/0000", instr_valid, instr);
        end
        wait_valid(10, c);
        n_checks++;
        if (c !== 3 || instr !== mem[0]) begin
            n_fail++;
            $display("FAIL rst_in_wait_restart: gap=%0d instr=%h required 3/%h", c, instr, mem[0]);
        end
    endtask

    // Random ready/halt/jump traffic against an address-sequence model:
    // each delivered word is mem[a]; the next is at the jump target if a jump
    // accompanied the handshake, otherwise at a+1.
    task automatic test_random();
        logic [15:0] exp_addr;
        logic [15:0] prev_instr;
        logic        prev_pending;
        int          delivered;
        do_reset();
        exp_addr     = 16'h0000;
        prev_instr   = 16'h0000;
        prev_pending = 1'b0;
        delivered    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            instr_ready = ($urandom_range(3) != 0);
            halt        = ($urandom_range(4) == 0);
            jump_req    = ($urandom_range(2) == 0);
            jump_addr   = 16'($urandom_range(200));
            @(negedge clk);
            if (mem_en) begin
                n_checks++;
                if (halt !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== pc_value) begin
                    n_fail++;
                    $display("FAIL rand_fetch@%0d: halt=%b valid=%b addr=%h pc=%h required no halt, no valid, addr=pc",
                             cyc, halt, instr_valid, mem_addr, pc_value);
                end
            end
            if (instr_valid && prev_pending) begin
                n_checks++;
                if (instr !== prev_instr) begin
                    n_fail++;
                    $display("FAIL rand_stable@%0d: got %h required %h", cyc, instr, prev_instr);
                end
            end
            if (instr_valid && instr_ready) begin
                n_checks++;
                if (instr !== mem[exp_addr[7:0]]) begin
                    n_fail++;
                    $display("FAIL rand_deliver@%0d: got %h required %h (addr %h)",
                             cyc, instr, mem[exp_addr[7:0]], exp_addr);
                end
                exp_addr = jump_req ? jump_addr : exp_addr + 16'd1;
                delivered++;
            end
            prev_pending = instr_valid && !instr_ready;
            prev_instr   = instr;
            tick();
        end
        instr_ready = 1'b0;
        jump_req    = 1'b0;
        halt        = 1'b0;
        n_checks++;
        if (delivered < 200 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_progress: delivered=%0d fault=%b required >=200 and 0", delivered, fault);
        end
    endtask

`ifdef IFETCH_BOUND_CHECK_EN
    task automatic test_fault();
        int c;
        do_reset();
        instr_ready = 1'b1;
        wait_valid(10, c);
        jump_req  = 1'b1;
        jump_addr = 16'h0100;
        tick();
        jump_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_fetch: en=%b required 0", mem_en);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (fault !== 1'b1 || mem_en !== 1'b0 || pc_ce !== 1'b0 || pc_load !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_sticky[%0d]: fault=%b en=%b ce=%b load=%b required 1/0/0/0",
                         i, fault, mem_en, pc_ce, pc_load);
            end
        end
        do_reset();
        @(negedge clk);
        n_checks++;
        if (fault !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b required 0", fault);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 16'hA000 + 16'(i);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        test_reset();
        test_backpressure();
        test_jump();
        test_halt();
        test_reset_in_wait();
        for (int i = 0; i < 256; i++)
            mem[i] = 16'($urandom);
        test_random();
`ifdef IFETCH_BOUND_CHECK_EN
        test_fault();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
